// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its prefetch queue.
package fetch_pkg;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 16'h0000;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOLD,
      DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } fetch_entry_t;

   // PC arithmetic wraps modulo 2^16.
   function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc);
      return pc + WORD_W'(1);
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Memory, execution and redirect signals of the fetch stage; master = fetch side.
interface instruction_fetch_if #(
   parameter int DEPTH = 2
);
   logic                          mem_req;
   logic [fetch_pkg::WORD_W-1:0]  mem_addr;
   logic                          mem_ack;
   logic [fetch_pkg::WORD_W-1:0]  mem_rdata;
   logic                          ir_valid;
   logic [fetch_pkg::WORD_W-1:0]  ir_data;
   logic [fetch_pkg::WORD_W-1:0]  ir_pc;
   logic                          ir_ready;
   logic                          redirect;
   logic [fetch_pkg::WORD_W-1:0]  redirect_pc;
   logic [$clog2(DEPTH):0]        q_count;

   modport master (
      output mem_req, mem_addr, ir_valid, ir_data, ir_pc, q_count,
      input  mem_ack, mem_rdata, ir_ready, redirect, redirect_pc
   );

   modport slave (
      input  mem_req, mem_addr, ir_valid, ir_data, ir_pc, q_count,
      output mem_ack, mem_rdata, ir_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr}; flush wins over push and pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output logic [CW-1:0] count,
   output logic         head_valid,
   output fetch_entry_t head_entry
);

   fetch_entry_t    slots_q [DEPTH];
   fetch_entry_t    slots_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            do_pop;

   assign do_pop = pop && (count_q != '0);

   always_comb begin
      slots_d  = slots_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            slots_d[wr_ptr_q] = push_entry;
            wr_ptr_d          = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            slots_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         slots_q  <= slots_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count      = count_q;
   assign head_valid = (count_q != '0);
   assign head_entry = slots_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: req/ack word fetches into a prefetch queue, valid/ready to execution, branch redirect.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int                DEPTH    = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   instruction_fetch_if.master  fetch_bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [WORD_W-1:0] req_addr_q, req_addr_d;

   logic              push;
   logic              pop;
   logic              flush;
   logic [CW-1:0]     count;
   logic [CW-1:0]     occ_next;
   logic              head_valid;
   fetch_entry_t      push_entry;
   fetch_entry_t      head_entry;

   assign pop        = head_valid && fetch_bus.ir_ready;
   assign push_entry = '{pc: req_addr_q, instr: fetch_bus.mem_rdata};

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk        (clock),
      .rst_n      (reset_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (flush),
      .count      (count),
      .head_valid (head_valid),
      .head_entry (head_entry)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_addr_d = req_addr_q;
      push       = 1'b0;
      flush      = fetch_bus.redirect;
      occ_next   = count + CW'(fetch_bus.mem_ack) - CW'(pop);
      if (fetch_bus.redirect) begin
         fetch_pc_d = fetch_bus.redirect_pc;
         case (state_q)
            // An unacked request must stay stable, so it is drained rather than abandoned.
            FETCH, DRAIN: begin
               if (fetch_bus.mem_ack) begin
                  state_d    = FETCH;
                  req_addr_d = fetch_bus.redirect_pc;
               end else begin
                  state_d = DRAIN;
               end
            end
            default: begin
               state_d    = FETCH;
               req_addr_d = fetch_bus.redirect_pc;
            end
         endcase
      end else begin
         unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
               if (fetch_bus.mem_ack) begin
                  push       = 1'b1;
                  fetch_pc_d = pc_next(req_addr_q);
                  if (occ_next < CW'(DEPTH)) begin
                     req_addr_d = pc_next(req_addr_q);
                  end else begin
                     state_d = HOLD;
                  end
               end
            end
            HOLD: begin
               if (count < CW'(DEPTH)) begin
                  state_d    = FETCH;
                  req_addr_d = fetch_pc_q;
               end
            end
            DRAIN: begin
               if (fetch_bus.mem_ack) begin
                  state_d    = FETCH;
                  req_addr_d = fetch_pc_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      fetch_bus.mem_req  = (state_q == FETCH) || (state_q == DRAIN);
      fetch_bus.mem_addr = req_addr_q;
      fetch_bus.ir_valid = head_valid;
      fetch_bus.ir_data  = head_entry.instr;
      fetch_bus.ir_pc    = head_entry.pc;
      fetch_bus.q_count  = count;
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a variable-latency req/ack memory model.
module tb_instruction_fetch;
   import fetch_pkg::*;

   localparam int DEPTH = 2;
   localparam int LIMIT = 60;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   instruction_fetch_if #(.DEPTH(DEPTH)) bus ();

   instruction_fetch #(
      .RESET_PC (16'h0000),
      .DEPTH    (DEPTH)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .fetch_bus (bus)
   );

   int checks = 0;
   int fails  = 0;

   // Memory: acks mem_lat cycles after a request is first seen, data = addr ^ A5A5.
   int          mem_lat = 1;
   int          mem_cnt;
   logic        mem_ack_r;
   logic [15:0] mem_rdata_r;
   assign bus.mem_ack   = mem_ack_r;
   assign bus.mem_rdata = mem_rdata_r;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_ack_r   <= 1'b0;
         mem_cnt     <= 0;
         mem_rdata_r <= '0;
      end else if (mem_ack_r) begin
         mem_ack_r <= 1'b0;
         mem_cnt   <= 0;
      end else if (bus.mem_req) begin
         if (mem_cnt + 1 >= mem_lat) begin
            mem_ack_r   <= 1'b1;
            mem_rdata_r <= bus.mem_addr ^ 16'hA5A5;
         end else begin
            mem_cnt <= mem_cnt + 1;
         end
      end else begin
         mem_cnt <= 0;
      end
   end

   int          cyc;
   logic [15:0] ack_addr[$];
   int          ack_cyc[$];
   logic [15:0] pop_pc[$];
   logic [15:0] pop_data[$];
   int          pop_cyc[$];

   always @(posedge clock) begin
      if (reset_n) begin
         if (bus.mem_req && bus.mem_ack) begin
            ack_addr.push_back(bus.mem_addr);
            ack_cyc.push_back(cyc);
         end
         if (bus.ir_valid && bus.ir_ready && !bus.redirect) begin
            pop_pc.push_back(bus.ir_pc);
            pop_data.push_back(bus.ir_data);
            pop_cyc.push_back(cyc);
         end
         cyc = cyc + 1;
      end
   end

   task automatic clear_logs();
      cyc = 0;
      ack_addr.delete();
      ack_cyc.delete();
      pop_pc.delete();
      pop_data.delete();
      pop_cyc.delete();
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      bus.redirect = 1'b0;
      repeat (2) @(negedge clock);
      clear_logs();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.ir_ready    = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      mem_lat         = 1;
      reset_n         = 1'b0;
      repeat (2) @(negedge clock);
      checks += 6;
      if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
      if (bus.mem_addr !== 16'h0000) begin fails++; $display("FAIL rst_mem_addr: got %h expected 0000", bus.mem_addr); end
      if (bus.ir_valid !== 1'b0) begin fails++; $display("FAIL rst_ir_valid: got %b expected 0", bus.ir_valid); end
      if (bus.ir_data !== 16'h0000) begin fails++; $display("FAIL rst_ir_data: got %h expected 0000", bus.ir_data); end
      if (bus.ir_pc !== 16'h0000) begin fails++; $display("FAIL rst_ir_pc: got %h expected 0000", bus.ir_pc); end
      if (bus.q_count !== 2'd0) begin fails++; $display("FAIL rst_q_count: got %0d expected 0", bus.q_count); end
      clear_logs();
      reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if (!(bus.mem_req === 1'b1 && bus.mem_addr === 16'h0000)) begin
         fails++;
         $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0000", bus.mem_req, bus.mem_addr);
      end
   endtask

   task automatic test_stream();
      int k = 0;
      while (pop_pc.size() < 3 && k < LIMIT) begin @(negedge clock); k++; end
      if (k >= LIMIT) begin
         checks++; fails++;
         $display("FAIL stream_timeout: got %0d pops expected 3", pop_pc.size());
         return;
      end
      for (int i = 0; i < 3; i++) begin
         checks += 3;
         if (ack_addr[i] !== 16'(i)) begin fails++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", i, ack_addr[i], 16'(i)); end
         if (pop_pc[i] !== 16'(i)) begin fails++; $display("FAIL stream_ir_pc[%0d]: got %h expected %h", i, pop_pc[i], 16'(i)); end
         if (pop_data[i] !== (16'(i) ^ 16'hA5A5)) begin fails++; $display("FAIL stream_ir_data[%0d]: got %h expected %h", i, pop_data[i], 16'(i) ^ 16'hA5A5); end
      end
      checks += 2;
      if (ack_cyc[1] - ack_cyc[0] !== 2) begin fails++; $display("FAIL stream_throughput: got %0d cycles expected 2", ack_cyc[1] - ack_cyc[0]); end
      if (pop_cyc[0] - ack_cyc[0] !== 1) begin fails++; $display("FAIL stream_latency: got %0d cycles expected 1", pop_cyc[0] - ack_cyc[0]); end
   endtask

   task automatic test_fill();
      mem_lat = 1;
      bus.ir_ready = 1'b0;
      do_reset();
      repeat (12) @(negedge clock);
      checks += 6;
      if (ack_addr.size() !== 2) begin fails++; $display("FAIL fill_acks: got %0d expected 2", ack_addr.size()); end
      if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL fill_mem_req: got %b expected 0", bus.mem_req); end
      if (bus.q_count !== 2'd2) begin fails++; $display("FAIL fill_q_count: got %0d expected 2", bus.q_count); end
      if (dut.state_q !== HOLD) begin fails++; $display("FAIL fill_state: got %0d expected %0d", dut.state_q, HOLD); end
      if (bus.ir_pc !== 16'h0000) begin fails++; $display("FAIL fill_head_pc: got %h expected 0000", bus.ir_pc); end
      if (bus.ir_data !== 16'hA5A5) begin fails++; $display("FAIL fill_head_data: got %h expected a5a5", bus.ir_data); end
      bus.ir_ready = 1'b1;
      @(negedge clock);
      bus.ir_ready = 1'b0;
      checks += 2;
      if (bus.q_count !== 2'd1) begin fails++; $display("FAIL pop_q_count: got %0d expected 1", bus.q_count); end
      if (bus.ir_pc !== 16'h0001) begin fails++; $display("FAIL pop_head_pc: got %h expected 0001", bus.ir_pc); end
      @(negedge clock);
      checks++;
      if (!(bus.mem_req === 1'b1 && bus.mem_addr === 16'h0002)) begin
         fails++;
         $display("FAIL refill_req: got req=%b addr=%h expected req=1 addr=0002", bus.mem_req, bus.mem_addr);
      end
   endtask

   task automatic test_redirect_inflight();
      int k = 0;
      int n;
      int moved = 0;
      mem_lat = 3;
      bus.ir_ready = 1'b1;
      do_reset();
      while (!(bus.mem_req && bus.mem_addr == 16'h0003) && k < LIMIT) begin @(negedge clock); k++; end
      if (k >= LIMIT) begin
         checks++; fails++;
         $display("FAIL drain_setup_timeout: got addr=%h expected 0003", bus.mem_addr);
         return;
      end
      n = pop_pc.size();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0010;
      @(negedge clock);
      bus.redirect = 1'b0;
      checks += 2;
      if (bus.ir_valid !== 1'b0) begin fails++; $display("FAIL drain_ir_valid: got %b expected 0", bus.ir_valid); end
      if (!(bus.mem_req === 1'b1 && bus.mem_addr === 16'h0003)) begin
         fails++; $display("FAIL drain_hold_req: got req=%b addr=%h expected req=1 addr=0003", bus.mem_req, bus.mem_addr);
      end
      k = 0;
      while (!bus.mem_ack && k < LIMIT) begin
         if (bus.mem_addr !== 16'h0003 || bus.mem_req !== 1'b1) moved++;
         @(negedge clock); k++;
      end
      checks++;
      if (k >= LIMIT || moved != 0) begin
         fails++; $display("FAIL drain_stable: got %0d unstable cycles expected 0", moved + (k >= LIMIT ? 1 : 0));
      end
      @(negedge clock);
      checks++;
      if (!(bus.mem_req === 1'b1 && bus.mem_addr === 16'h0010)) begin
         fails++; $display("FAIL drain_next_req: got req=%b addr=%h expected req=1 addr=0010", bus.mem_req, bus.mem_addr);
      end
      k = 0;
      while (pop_pc.size() <= n && k < LIMIT) begin @(negedge clock); k++; end
      checks += 2;
      if (pop_pc.size() <= n) begin
         fails += 2; $display("FAIL drain_pop_timeout: got %0d pops expected %0d", pop_pc.size(), n + 1);
      end else begin
         if (pop_pc[n] !== 16'h0010) begin fails++; $display("FAIL drain_first_pc: got %h expected 0010", pop_pc[n]); end
         if (pop_data[n] !== 16'hA5B5) begin fails++; $display("FAIL drain_first_data: got %h expected a5b5", pop_data[n]); end
      end
   endtask

   task automatic test_redirect_ack();
      int k = 0;
      int n;
      mem_lat = 1;
      bus.ir_ready = 1'b0;
      do_reset();
      while (!(bus.mem_ack && bus.q_count == 2'd1) && k < LIMIT) begin @(negedge clock); k++; end
      if (k >= LIMIT) begin
         checks++; fails++;
         $display("FAIL ackredir_setup_timeout: got q_count=%0d expected 1", bus.q_count);
         return;
      end
      n = pop_pc.size();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'h0040;
      bus.ir_ready    = 1'b1;
      @(negedge clock);
      bus.redirect = 1'b0;
      checks += 4;
      if (bus.q_count !== 2'd0) begin fails++; $display("FAIL ackredir_q_count: got %0d expected 0", bus.q_count); end
      if (bus.ir_valid !== 1'b0) begin fails++; $display("FAIL ackredir_ir_valid: got %b expected 0", bus.ir_valid); end
      if (!(bus.mem_req === 1'b1 && bus.mem_addr === 16'h0040)) begin
         fails++; $display("FAIL ackredir_req: got req=%b addr=%h expected req=1 addr=0040", bus.mem_req, bus.mem_addr);
      end
      if (dut.state_q !== FETCH) begin fails++; $display("FAIL ackredir_state: got %0d expected %0d", dut.state_q, FETCH); end
      k = 0;
      while (pop_pc.size() <= n && k < LIMIT) begin @(negedge clock); k++; end
      checks += 2;
      if (pop_pc.size() <= n) begin
         fails += 2; $display("FAIL ackredir_pop_timeout: got %0d pops expected %0d", pop_pc.size(), n + 1);
      end else begin
         if (pop_pc[n] !== 16'h0040) begin fails++; $display("FAIL ackredir_first_pc: got %h expected 0040", pop_pc[n]); end
         if (pop_data[n] !== 16'hA5E5) begin fails++; $display("FAIL ackredir_first_data: got %h expected a5e5", pop_data[n]); end
      end
   endtask

   task automatic test_wrap();
      int k = 0;
      int n;
      int na;
      mem_lat = 1;
      bus.ir_ready = 1'b1;
      do_reset();
      while (!bus.mem_ack && k < LIMIT) begin @(negedge clock); k++; end
      if (k >= LIMIT) begin
         checks++; fails++;
         $display("FAIL wrap_setup_timeout: got ack=%b expected 1", bus.mem_ack);
         return;
      end
      n  = pop_pc.size();
      na = ack_addr.size();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 16'hFFFF;
      @(negedge clock);
      bus.redirect = 1'b0;
      k = 0;
      while (pop_pc.size() < n + 2 && k < LIMIT) begin @(negedge clock); k++; end
      checks += 6;
      if (pop_pc.size() < n + 2 || ack_addr.size() < na + 3) begin
         fails += 6; $display("FAIL wrap_timeout: got %0d pops expected %0d", pop_pc.size(), n + 2);
      end else begin
         if (ack_addr[na+1] !== 16'hFFFF) begin fails++; $display("FAIL wrap_req0: got %h expected ffff", ack_addr[na+1]); end
         if (ack_addr[na+2] !== 16'h0000) begin fails++; $display("FAIL wrap_req1: got %h expected 0000", ack_addr[na+2]); end
         if (pop_pc[n] !== 16'hFFFF) begin fails++; $display("FAIL wrap_pc0: got %h expected ffff", pop_pc[n]); end
         if (pop_pc[n+1] !== 16'h0000) begin fails++; $display("FAIL wrap_pc1: got %h expected 0000", pop_pc[n+1]); end
         if (pop_data[n] !== 16'h5A5A) begin fails++; $display("FAIL wrap_data0: got %h expected 5a5a", pop_data[n]); end
         if (pop_data[n+1] !== 16'hA5A5) begin fails++; $display("FAIL wrap_data1: got %h expected a5a5", pop_data[n+1]); end
      end
   endtask

   task automatic test_async_reset();
      int k = 0;
      mem_lat = 3;
      bus.ir_ready = 1'b1;
      do_reset();
      while (!(bus.mem_req && bus.mem_addr == 16'h0002) && k < LIMIT) begin @(negedge clock); k++; end
      if (k >= LIMIT) begin
         checks++; fails++;
         $display("FAIL areset_setup_timeout: got addr=%h expected 0002", bus.mem_addr);
         return;
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks += 6;
      if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL areset_mem_req: got %b expected 0", bus.mem_req); end
      if (bus.mem_addr !== 16'h0000) begin fails++; $display("FAIL areset_mem_addr: got %h expected 0000", bus.mem_addr); end
      if (bus.ir_valid !== 1'b0) begin fails++; $display("FAIL areset_ir_valid: got %b expected 0", bus.ir_valid); end
      if (bus.ir_data !== 16'h0000) begin fails++; $display("FAIL areset_ir_data: got %h expected 0000", bus.ir_data); end
      if (bus.ir_pc !== 16'h0000) begin fails++; $display("FAIL areset_ir_pc: got %h expected 0000", bus.ir_pc); end
      if (bus.q_count !== 2'd0) begin fails++; $display("FAIL areset_q_count: got %0d expected 0", bus.q_count); end
      @(negedge clock);
      clear_logs();
      reset_n = 1'b1;
      @(negedge clock);
      checks++;
      if (!(bus.mem_req === 1'b1 && bus.mem_addr === 16'h0000)) begin
         fails++; $display("FAIL areset_first_req: got req=%b addr=%h expected req=1 addr=0000", bus.mem_req, bus.mem_addr);
      end
      k = 0;
      while (pop_pc.size() < 1 && k < LIMIT) begin @(negedge clock); k++; end
      checks++;
      if (pop_pc.size() < 1) begin
         fails++; $display("FAIL areset_pop_timeout: got 0 pops expected 1");
      end else if (pop_pc[0] !== 16'h0000) begin
         fails++; $display("FAIL areset_first_pc: got %h expected 0000", pop_pc[0]);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_fill();
      test_redirect_inflight();
      test_redirect_ack();
      test_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
